// File: rtl/i2c_target_mem.sv
// I2C target exposing a 128 x 8 register memory with an auto-incrementing
// word pointer. SCL/SDA are oversampled by clk; SDA is driven open-drain via
// sda_oe. The write-event port (mem_we/mem_waddr/mem_wdata) is a valid-only
// strobe: mem_we is high for exactly one clk per committed byte, the address
// and data are valid in that same cycle, and there is no ready/back-pressure.
module i2c_target_mem #(
  parameter logic [6:0] DEV_ADDR = 7'h50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       busy,
  output logic       mem_we,
  output logic [6:0] mem_waddr,
  output logic [7:0] mem_wdata,
  output logic [3:0] dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ACK_ADDR  = 4'd2,
    S_PTR       = 4'd3,
    S_ACK_PTR   = 4'd4,
    S_WDATA     = 4'd5,
    S_ACK_WDATA = 4'd6,
    S_RDATA     = 4'd7,
    S_RACK      = 4'd8,
    S_IGNORE    = 4'd9
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_scl_s1, r_scl_s2, r_scl_h;
  logic       r_sda_s1, r_sda_s2, r_sda_h;
  logic [7:0] r_shift;
  logic [3:0] r_cnt;
  logic       r_phase;   // ACK states: ACK driven; RACK: controller ACKed
  logic [6:0] r_ptr;
  logic       r_sda_oe;
  logic       r_busy;
  logic       r_mem_we;
  logic [6:0] r_mem_waddr;
  logic [7:0] r_mem_wdata;
  logic [7:0] r_mem [128];

  logic       w_scl_rise, w_scl_fall, w_start, w_stop, w_last_bit;
  logic [7:0] w_byte;

  assign w_scl_rise = r_scl_s2 & ~r_scl_h;
  assign w_scl_fall = ~r_scl_s2 & r_scl_h;
  assign w_start    = r_scl_s2 & r_scl_h & ~r_sda_s2 & r_sda_h;
  assign w_stop     = r_scl_s2 & r_scl_h & r_sda_s2 & ~r_sda_h;
  assign w_byte     = {r_shift[6:0], r_sda_s2};
  assign w_last_bit = (r_cnt == 4'd7);

  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign mem_we    = r_mem_we;
  assign mem_waddr = r_mem_waddr;
  assign mem_wdata = r_mem_wdata;
  assign dbg_state = r_state;

  // Two-flop synchronizers plus a history flop for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_scl_s1 <= 1'b1; r_scl_s2 <= 1'b1; r_scl_h <= 1'b1;
      r_sda_s1 <= 1'b1; r_sda_s2 <= 1'b1; r_sda_h <= 1'b1;
    end else begin
      r_scl_s1 <= scl_i; r_scl_s2 <= r_scl_s1; r_scl_h <= r_scl_s2;
      r_sda_s1 <= sda_i; r_sda_s2 <= r_sda_s1; r_sda_h <= r_sda_s2;
    end
  end

  // Next-state logic; bus START/STOP outrank any bit-level progress.
  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_ADDR;
    end else begin
      case (r_state)
        S_ADDR:      if (w_scl_rise && w_last_bit)
                       w_state_nxt = (w_byte[7:1] == DEV_ADDR) ? S_ACK_ADDR : S_IGNORE;
        S_ACK_ADDR:  if (w_scl_fall && r_phase)
                       w_state_nxt = r_shift[0] ? S_RDATA : S_PTR;
        S_PTR:       if (w_scl_rise && w_last_bit) w_state_nxt = S_ACK_PTR;
        S_ACK_PTR:   if (w_scl_fall && r_phase) w_state_nxt = S_WDATA;
        S_WDATA:     if (w_scl_rise && w_last_bit) w_state_nxt = S_ACK_WDATA;
        S_ACK_WDATA: if (w_scl_fall && r_phase) w_state_nxt = S_WDATA;
        S_RDATA:     if (w_scl_fall && (r_cnt == 4'd8)) w_state_nxt = S_RACK;
        S_RACK: begin
          if (w_scl_rise && r_sda_s2) w_state_nxt = S_IGNORE;
          else if (w_scl_fall && r_phase) w_state_nxt = S_RDATA;
        end
        default: ;
      endcase
    end
  end

  // State register, shift/pointer datapath, memory and bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_phase     <= 1'b0;
      r_ptr       <= '0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_waddr <= '0;
      r_mem_wdata <= '0;
      for (int i = 0; i < 128; i++) r_mem[i] <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mem_we <= 1'b0;
      if (w_stop) begin
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
        r_cnt    <= '0;
        r_phase  <= 1'b0;
      end else if (w_start) begin
        r_sda_oe <= 1'b0;
        r_cnt    <= '0;
        r_phase  <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_PTR, S_WDATA: begin
            if (w_scl_rise) begin
              r_shift <= w_byte;
              r_cnt   <= w_last_bit ? 4'd0 : r_cnt + 4'd1;
              r_phase <= 1'b0;
              if (w_last_bit) begin
                if (r_state == S_ADDR) begin
                  r_busy <= (w_byte[7:1] == DEV_ADDR);
                end else if (r_state == S_PTR) begin
                  r_ptr <= w_byte[6:0];
                end else begin
                  r_mem[r_ptr] <= w_byte;
                  r_mem_we     <= 1'b1;
                  r_mem_waddr  <= r_ptr;
                  r_mem_wdata  <= w_byte;
                  r_ptr        <= r_ptr + 7'd1;
                end
              end
            end
          end
          S_ACK_ADDR, S_ACK_PTR, S_ACK_WDATA: begin
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_sda_oe <= 1'b1;
                r_phase  <= 1'b1;
              end else begin
                r_phase <= 1'b0;
                if (r_state == S_ACK_ADDR && r_shift[0]) begin
                  r_shift  <= {r_mem[r_ptr][6:0], 1'b0};
                  r_sda_oe <= ~r_mem[r_ptr][7];
                  r_ptr    <= r_ptr + 7'd1;
                  r_cnt    <= 4'd1;
                end else begin
                  r_sda_oe <= 1'b0;
                end
              end
            end
          end
          S_RDATA: begin
            if (w_scl_fall) begin
              if (r_cnt == 4'd8) begin
                r_sda_oe <= 1'b0;
                r_cnt    <= '0;
                r_phase  <= 1'b0;
              end else begin
                r_sda_oe <= ~r_shift[7];
                r_shift  <= {r_shift[6:0], 1'b0};
                r_cnt    <= r_cnt + 4'd1;
              end
            end
          end
          S_RACK: begin
            if (w_scl_rise) begin
              if (r_sda_s2) r_busy <= 1'b0;
              else r_phase <= 1'b1;
            end else if (w_scl_fall && r_phase) begin
              r_phase  <= 1'b0;
              r_shift  <= {r_mem[r_ptr][6:0], 1'b0};
              r_sda_oe <= ~r_mem[r_ptr][7];
              r_ptr    <= r_ptr + 7'd1;
              r_cnt    <= 4'd1;
            end
          end
          default: r_sda_oe <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_mem.sv
// Bench for i2c_target_mem: bit-banged I2C controller, open-drain bus model,
// table of write/read-back vectors plus hand-written corner sequences.
module tb_i2c_target_mem;

  logic       clk;
  logic       rst;
  logic       m_scl;
  logic       m_sda;
  logic       sda_line;
  logic       sda_oe;
  logic       busy;
  logic       mem_we;
  logic [6:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [3:0] dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int oe_cnt = 0;

  logic [14:0] exp_q[$];
  logic [14:0] got_q[$];

  typedef struct {
    logic [6:0] ptr;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [6:0] exp_a0;
    logic [6:0] exp_a1;
    logic [7:0] exp_r0;
    logic [7:0] exp_r1;
  } vec_t;

  vec_t vecs[4];

  assign sda_line = m_sda & ~sda_oe;

  i2c_target_mem #(.DEV_ADDR(7'h50)) dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (m_scl),
    .sda_i     (sda_line),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // Monitor: record every cycle with mem_we high and count sda_oe cycles.
  always @(negedge clk) begin
    if (mem_we) got_q.push_back({mem_waddr, mem_wdata});
    if (sda_oe) oe_cnt = oe_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wq();
    repeat (8) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b0; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wq();
    m_scl = 1'b1; wq();
    m_sda = 1'b1; wq();
  endtask

  task automatic write_bit(input logic b);
    m_sda = b;    wq();
    m_scl = 1'b1; wq(); wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic read_bit(output logic b);
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    b = sda_line; wq();
    m_scl = 1'b0; wq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(~ack);
  endtask

  // Scoreboard drain: every expected commit must match one observed pulse.
  task automatic check_writes(input string name);
    logic [14:0] e;
    logic [14:0] g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        check({name, " missing mem_we"}, 32'h0, {17'h0, e});
      end else begin
        g = got_q.pop_front();
        check({name, " mem_we addr/data"}, {17'h0, g}, {17'h0, e});
      end
    end
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      check({name, " unexpected mem_we"}, {17'h0, g}, 32'h0);
    end
  endtask

  task automatic do_write(input logic [6:0] ptr, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [6:0] a0, input logic [6:0] a1);
    logic ack;
    exp_q.push_back({a0, d0});
    exp_q.push_back({a1, d1});
    i2c_start();
    write_byte(8'hA0, ack);        check("wr addr ack", ack, 1);
    check("wr busy after addr", busy, 1);
    write_byte({1'b0, ptr}, ack);  check("wr ptr ack", ack, 1);
    write_byte(d0, ack);           check("wr d0 ack", ack, 1);
    write_byte(d1, ack);           check("wr d1 ack", ack, 1);
    i2c_stop();
    wq();
    check("busy after stop", busy, 0);
    check_writes("write");
  endtask

  task automatic do_read(input logic [6:0] ptr, input logic [7:0] e0, input logic [7:0] e1);
    logic       ack;
    logic [7:0] r0;
    logic [7:0] r1;
    i2c_start();
    write_byte(8'hA0, ack);        check("rd addr ack", ack, 1);
    write_byte({1'b0, ptr}, ack);  check("rd ptr ack", ack, 1);
    i2c_start();
    write_byte(8'hA1, ack);        check("rd addr R ack", ack, 1);
    read_byte(r0, 1'b1);
    read_byte(r1, 1'b0);
    check("read byte 0", r0, e0);
    check("read byte 1", r1, e1);
    check("busy after nack", busy, 0);
    i2c_stop();
    wq();
    check_writes("read");
  endtask

  initial begin
    logic       ack;
    logic       b;
    int         oe_before;

    vecs[0] = '{ptr: 7'h10, d0: 8'h5A, d1: 8'hC3, exp_a0: 7'h10, exp_a1: 7'h11, exp_r0: 8'h5A, exp_r1: 8'hC3};
    vecs[1] = '{ptr: 7'h7F, d0: 8'h11, d1: 8'h22, exp_a0: 7'h7F, exp_a1: 7'h00, exp_r0: 8'h11, exp_r1: 8'h22};
    vecs[2] = '{ptr: 7'h20, d0: 8'h00, d1: 8'hFF, exp_a0: 7'h20, exp_a1: 7'h21, exp_r0: 8'h00, exp_r1: 8'hFF};
    vecs[3] = '{ptr: 7'h45, d0: 8'hA5, d1: 8'h3C, exp_a0: 7'h45, exp_a1: 7'h46, exp_r0: 8'hA5, exp_r1: 8'h3C};

    // Reset and idle bus.
    rst = 1'b1; m_scl = 1'b1; m_sda = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset sda_oe", sda_oe, 0);
    check("reset busy", busy, 0);
    check("reset mem_we", mem_we, 0);
    check("reset mem_waddr", mem_waddr, 0);
    check("reset mem_wdata", mem_wdata, 0);
    check("reset state", dbg_state, 0);

    // Table: write two bytes, then read them back through a repeated start.
    for (int i = 0; i < 4; i++) begin
      do_write(vecs[i].ptr, vecs[i].d0, vecs[i].d1, vecs[i].exp_a0, vecs[i].exp_a1);
      do_read(vecs[i].ptr, vecs[i].exp_r0, vecs[i].exp_r1);
    end

    // Address mismatch: no ACK, no drive, no commit, not busy.
    oe_before = oe_cnt;
    i2c_start();
    write_byte(8'hA2, ack);  check("mismatch addr ack", ack, 0);
    check("mismatch busy", busy, 0);
    write_byte(8'h10, ack);  check("mismatch 2nd byte ack", ack, 0);
    i2c_stop();
    wq();
    check("mismatch sda_oe cycles", oe_cnt - oe_before, 0);
    check_writes("mismatch");

    // STOP after 4 bits of a data byte: partial byte discarded.
    i2c_start();
    write_byte(8'hA0, ack);  check("stopmid addr ack", ack, 1);
    write_byte(8'h30, ack);  check("stopmid ptr ack", ack, 1);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    wq();
    check("stopmid state idle", dbg_state, 0);
    check("stopmid busy", busy, 0);
    check_writes("stopmid");
    do_write(7'h30, 8'h77, 8'h88, 7'h30, 7'h31);
    do_read(7'h30, 8'h77, 8'h88);

    // Reset while the target is driving bit 3 of a read byte (0x5A at 0x10).
    i2c_start();
    write_byte(8'hA0, ack);
    write_byte(8'h10, ack);
    i2c_start();
    write_byte(8'hA1, ack);  check("rstmid addr ack", ack, 1);
    for (int i = 0; i < 4; i++) read_bit(b);
    check("rstmid busy before reset", busy, 1);
    check("rstmid bit3 drive", sda_oe, 0);
    #2 rst = 1'b1;
    #1;
    check("rstmid sda_oe", sda_oe, 0);
    check("rstmid busy", busy, 0);
    check("rstmid mem_we", mem_we, 0);
    check("rstmid mem_waddr", mem_waddr, 0);
    check("rstmid mem_wdata", mem_wdata, 0);
    m_sda = 1'b1; wq();
    m_scl = 1'b1; wq();
    rst = 1'b0;
    wq();
    check("rstmid state idle", dbg_state, 0);
    do_read(7'h10, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/i2c_target_mem.md
# i2c_target_mem

I2C target (slave) block exposing a 128 x 8 register memory on a two-wire open-drain bus. It is the responder side for our I2C controller: it detects START/STOP, matches a 7-bit device address, and accepts a word pointer. It then either writes incoming bytes into memory or returns memory bytes to the controller, auto-incrementing the pointer. It sits behind the pad open-drain buffers; a write-event port lets the testbench scoreboard every committed write.

## Interface
- `DEV_ADDR`, default 7'h50: 7-bit device address this target answers to.
- `clk`  in  1: system clock; must be at least 8x the SCL frequency.
- `rst`  in  1: asynchronous, active-high reset.
- `scl_i`  in  1: SCL bus level, asynchronous to `clk`.
- `sda_i`  in  1: SDA bus level, asynchronous to `clk`.
- `sda_oe`  out  1: 1 pulls SDA low; 0 releases it. The pad ties the output to 0.
- `busy`  out  1: high from an address-matched START until STOP or NACK termination.
- `mem_we`  out  1: one-`clk` pulse when a data byte is committed.
- `mem_waddr`  out  7: pointer of the committed byte, valid with `mem_we`.
- `mem_wdata`  out  8: committed byte, valid with `mem_we`.

## Operation
- **Input conditioning**
  - `scl_i` and `sda_i` each pass through a 2-flop synchronizer plus 1 history flop.
  - All events below use the synchronized values.
  - SCL rise/fall: sync value differs from history.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- **Bit rules**
  - All bytes are MSB first.
  - Received bits are sampled on SCL rise.
  - `sda_oe` changes only on the `clk` after an SCL fall.
- **States:** IDLE, ADDR, ACK_ADDR, PTR, ACK_PTR, WDATA, ACK_WDATA, RDATA, RACK, IGNORE.
- **IDLE:** `sda_oe`=0, `busy`=0. START goes to ADDR with bit count 0.
- **ADDR:** shift 8 bits.
  - On the 8th SCL rise, compare bits[7:1] with `DEV_ADDR`.
  - Match: ACK_ADDR, `busy`=1.
  - Mismatch: IGNORE, with no ACK driven.
- **ACK_ADDR**
  - Next SCL fall: `sda_oe`=1.
  - The following SCL fall (end of the 9th clock) depends on R/W:
    - W: release, go to PTR.
    - R: load `mem[ptr]`, `ptr`<=`ptr`+1, drive bit7 (`sda_oe`=~bit7), go to RDATA.
- **PTR:** shift 8 bits. On the 8th rise, `ptr`<=byte[6:0]; byte[7] is ignored. Go to ACK_PTR.
- **ACK_PTR:** same ACK as ACK_ADDR, then go to WDATA.
- **WDATA:** shift 8 bits. On the 8th rise:
  - `mem[ptr]`<=byte.
  - Pulse `mem_we` with `mem_waddr`=`ptr`, `mem_wdata`=byte.
  - `ptr`<=`ptr`+1, then go to ACK_WDATA.
- **ACK_WDATA:** ACK, then return to WDATA. Multi-byte writes are unlimited.
- **RDATA**
  - Each SCL fall drives the next bit.
  - After the 8th bit's SCL fall, release `sda_oe` and go to RACK.
- **RACK:** sample SDA on the 9th SCL rise.
  - 0 (ACK): at the next SCL fall, load `mem[ptr]`, `ptr`++, drive bit7, go to RDATA.
  - 1 (NACK): go to IGNORE, `busy`=0.
- **IGNORE:** `sda_oe`=0. Wait for START (go to ADDR) or STOP (go to IDLE).
- **Pointer arithmetic:** 7-bit, wraps 7'h7F to 7'h00 for both reads and writes. `ptr` persists across transactions; reset value is 0.
- **Precedence**
  - STOP in any state: IDLE, `sda_oe`=0, `busy`=0 on the next `clk`. A partial byte is discarded.
  - START in any state (repeated start): ADDR, bit count 0, `sda_oe`=0. `ptr` is kept, so a write-pointer-then-repeated-start-read reads from the new pointer.
  - START/STOP detection overrides any bit processing in the same `clk`.
- **Reset**
  - `rst` forces IDLE immediately, clearing `sda_oe`, `busy`, `mem_we`, `mem_waddr`, `mem_wdata`, `ptr`, the shift register, bit count and sync flops (to 1).
  - Memory contents are cleared to 0.
  - After reset release, a bus already mid-transfer is ignored until the next START.

## Timing
- Synchronizer latency: 2 `clk`. Event detection adds 1 `clk`. Total 3 `clk` from a pin edge to action.
- `sda_oe` updates 1 `clk` after the detected SCL fall, well inside the low phase given the 8x clock ratio.
- `mem_we`: exactly 1 `clk`, in the cycle after the 8th SCL rise of a write byte.
- Read data reflects memory as of the load cycle (at the SCL fall that starts the byte).
- A write committed by another transaction is visible on the next read load.
- No clock stretching: SCL is never driven.

## Test plan
- **Write, then read back:** START, 0xA0, ptr 0x10, data 0x5A, 0xC3, STOP.
  - ACK on all 4 bytes.
  - `mem_we` pulses at (0x10,0x5A) and (0x11,0xC3).
- **Pointer set, repeated start, read:** START, 0xA0, 0x10, rSTART, 0xA1, read 2 bytes (ACK then NACK), STOP.
  - SDA returns 0x5A, then 0xC3; `busy` falls after the NACK.
- **Address mismatch:** START, 0xA2 (addr 0x51).
  - `sda_oe` stays 0 for the whole transaction; no `mem_we`; `busy`=0.
- **Wrap-around:** write ptr 0x7F, data 0x11, 0x22.
  - Commits at 0x7F then 0x00; a subsequent read from 0x7F returns 0x11, 0x22.
- **STOP mid-byte:** STOP after 4 bits of a data byte.
  - No `mem_we`; IDLE; the next transaction works normally.
- **Reset mid-read:** assert `rst` while driving bit 3 of a read byte.
  - `sda_oe`=0 immediately, all outputs 0.
  - A subsequent read of ptr 0x10 returns 0x00.
